// File: rtl/tawas_regfile.sv
// Dual-slice 2x8 register file: combinational reads, AU commit at the edge, loads direct or via a
// 1-entry pending buffer (forwarded on reads); ls_rc_rdy_o drops only while that buffer is full.
module tawas_regfile #(
  parameter int DW   = 32,
  parameter int SELW = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            slice_i,
  input  logic [SELW-1:0] au_ra_sel_i,
  output logic [DW-1:0]   au_ra_o,
  input  logic [SELW-1:0] au_rb_sel_i,
  output logic [DW-1:0]   au_rb_o,
  input  logic            au_rc_vld_i,
  input  logic [SELW-1:0] au_rc_sel_i,
  input  logic [DW-1:0]   au_rc_i,
  input  logic [SELW-1:0] ls_rd_sel_i,
  output logic [DW-1:0]   ls_rd_o,
  input  logic            ls_rc_vld_i,
  output logic            ls_rc_rdy_o,
  input  logic            ls_rc_slice_i,
  input  logic [SELW-1:0] ls_rc_sel_i,
  input  logic [DW-1:0]   ls_rc_i
);
  localparam int NREG = 1 << SELW;

  logic [DW-1:0]   bank_q [2][NREG];
  logic            pend_vld_q, pend_vld_d;
  logic            pend_slice_q, pend_slice_d;
  logic [SELW-1:0] pend_sel_q, pend_sel_d;
  logic [DW-1:0]   pend_dat_q, pend_dat_d;

  logic            au_bank;
  logic            ls_hs, ls_collide, ls_same_reg, ls_direct, ls_capture;
  logic            pend_blocked, pend_drain, pend_cancel;
  logic            wr_en  [2];
  logic [SELW-1:0] wr_sel [2];
  logic [DW-1:0]   wr_dat [2];

  assign au_bank     = ~slice_i;
  assign ls_rc_rdy_o = ~pend_vld_q;
  assign ls_hs       = ls_rc_vld_i && ls_rc_rdy_o;
  assign ls_collide  = au_rc_vld_i && (ls_rc_slice_i == au_bank);
  assign ls_same_reg = ls_collide && (ls_rc_sel_i == au_rc_sel_i);
  assign ls_direct   = ls_hs && !ls_collide;
  assign ls_capture  = ls_hs && ls_collide && !ls_same_reg;

  // A younger AU write to the buffered register supersedes the pending load.
  assign pend_blocked = au_rc_vld_i && (pend_slice_q == au_bank);
  assign pend_cancel  = pend_vld_q && pend_blocked && (pend_sel_q == au_rc_sel_i);
  assign pend_drain   = pend_vld_q && !pend_blocked;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wr_en[b]  = 1'b0;
      wr_sel[b] = '0;
      wr_dat[b] = '0;
      if (au_rc_vld_i && (au_bank == b[0])) begin
        wr_en[b]  = 1'b1;
        wr_sel[b] = au_rc_sel_i;
        wr_dat[b] = au_rc_i;
      end else if (pend_drain && (pend_slice_q == b[0])) begin
        wr_en[b]  = 1'b1;
        wr_sel[b] = pend_sel_q;
        wr_dat[b] = pend_dat_q;
      end else if (ls_direct && (ls_rc_slice_i == b[0])) begin
        wr_en[b]  = 1'b1;
        wr_sel[b] = ls_rc_sel_i;
        wr_dat[b] = ls_rc_i;
      end
    end
  end

  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_slice_d = pend_slice_q;
    pend_sel_d   = pend_sel_q;
    pend_dat_d   = pend_dat_q;
    if (ls_capture) begin
      pend_vld_d   = 1'b1;
      pend_slice_d = ls_rc_slice_i;
      pend_sel_d   = ls_rc_sel_i;
      pend_dat_d   = ls_rc_i;
    end else if (pend_drain || pend_cancel) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        bank_q[0][i] <= '0;
        bank_q[1][i] <= '0;
      end
      pend_vld_q   <= 1'b0;
      pend_slice_q <= 1'b0;
      pend_sel_q   <= '0;
      pend_dat_q   <= '0;
    end else begin
      if (wr_en[0]) bank_q[0][wr_sel[0]] <= wr_dat[0];
      if (wr_en[1]) bank_q[1][wr_sel[1]] <= wr_dat[1];
      pend_vld_q   <= pend_vld_d;
      pend_slice_q <= pend_slice_d;
      pend_sel_q   <= pend_sel_d;
      pend_dat_q   <= pend_dat_d;
    end
  end

  function automatic logic [DW-1:0] rd_port(input logic [SELW-1:0] sel);
    if (pend_vld_q && (pend_slice_q == slice_i) && (pend_sel_q == sel))
      return pend_dat_q;
    return bank_q[slice_i][sel];
  endfunction

  assign au_ra_o = rd_port(au_ra_sel_i);
  assign au_rb_o = rd_port(au_rb_sel_i);
  assign ls_rd_o = rd_port(ls_rd_sel_i);

endmodule

// File: tb/tb_tawas_regfile.sv
// Bench for tawas_regfile: reset sweep, directed vector table, randomized run against a register-array model.
module tb_tawas_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        slice;
  logic [2:0]  ra_sel, rb_sel, ld_sel, au_sel, ls_sel;
  logic [31:0] ra, rb, ld, au_d, ls_d;
  logic        au_vld, ls_vld, ls_rdy, ls_slice;

  always #5 clk = ~clk;

  tawas_regfile #(.DW(32), .SELW(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .slice_i(slice),
    .au_ra_sel_i(ra_sel), .au_ra_o(ra), .au_rb_sel_i(rb_sel), .au_rb_o(rb),
    .au_rc_vld_i(au_vld), .au_rc_sel_i(au_sel), .au_rc_i(au_d),
    .ls_rd_sel_i(ld_sel), .ls_rd_o(ld),
    .ls_rc_vld_i(ls_vld), .ls_rc_rdy_o(ls_rdy), .ls_rc_slice_i(ls_slice),
    .ls_rc_sel_i(ls_sel), .ls_rc_i(ls_d)
  );

  typedef struct {
    logic        slice;
    logic [2:0]  ra_sel, rb_sel, ld_sel;
    logic        au_vld;
    logic [2:0]  au_sel;
    logic [31:0] au_d;
    logic        ls_vld, ls_slice;
    logic [2:0]  ls_sel;
    logic [31:0] ls_d;
    logic [31:0] e_ra, e_rb, e_ld;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[22];
  int vectors = 0;
  int miscompares = 0;

  // Reference: architectural registers plus an optional deferred load.
  logic [31:0] mb[2][8];
  logic        pv, ps;
  logic [2:0]  psel;
  logic [31:0] pd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [2:0] sel);
    if (pv && ps == slice && psel == sel) return pd;
    return mb[slice][sel];
  endfunction

  task automatic m_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) mb[b][r] = '0;
    pv = 1'b0; ps = 1'b0; psel = '0; pd = '0;
  endtask

  task automatic m_edge();
    logic other;
    logic pv_n;
    other = ~slice;
    pv_n  = pv;
    if (pv && au_vld && ps == other && psel == au_sel) pv_n = 1'b0;
    else if (pv && !(au_vld && ps == other)) begin
      mb[ps][psel] = pd;
      pv_n = 1'b0;
    end
    if (ls_vld && !pv) begin
      if (au_vld && ls_slice == other) begin
        if (ls_sel != au_sel) begin
          pv_n = 1'b1; ps = ls_slice; psel = ls_sel; pd = ls_d;
        end
      end else mb[ls_slice][ls_sel] = ls_d;
    end
    if (au_vld) mb[other][au_sel] = au_d;
    pv = pv_n;
  endtask

  task automatic idle();
    au_vld = 1'b0; au_sel = '0; au_d = '0;
    ls_vld = 1'b0; ls_slice = 1'b0; ls_sel = '0; ls_d = '0;
  endtask

  task automatic drive(input vec_t v);
    slice = v.slice; ra_sel = v.ra_sel; rb_sel = v.rb_sel; ld_sel = v.ld_sel;
    au_vld = v.au_vld; au_sel = v.au_sel; au_d = v.au_d;
    ls_vld = v.ls_vld; ls_slice = v.ls_slice; ls_sel = v.ls_sel; ls_d = v.ls_d;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ra"}, ra, m_rd(ra_sel));
    chk({tag, ".rb"}, rb, m_rd(rb_sel));
    chk({tag, ".ld"}, ld, m_rd(ld_sel));
    chk({tag, ".rdy"}, {31'd0, ls_rdy}, {31'd0, ~pv});
  endtask

  initial begin
    //        sl ra rb ld  au sel data          ls sl sel data          e_ra          e_rb          e_ld          rdy
    tbl[0]  = '{1, 3, 3, 3, 1, 3, 32'h12345678, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1};
    tbl[1]  = '{0, 3, 0, 3, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h12345678, 32'h0,        32'h12345678, 1};
    tbl[2]  = '{1, 3, 3, 3, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1};
    tbl[3]  = '{0, 0, 3, 0, 0, 0, 32'h0,        1, 1, 5, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'h0,        1};
    tbl[4]  = '{1, 5, 0, 5, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1};
    tbl[5]  = '{0, 3, 0, 0, 1, 2, 32'hA,        1, 1, 4, 32'hB,        32'h12345678, 32'h0,        32'h0,        1};
    tbl[6]  = '{1, 4, 2, 4, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hB,        32'hA,        32'hB,        0};
    tbl[7]  = '{0, 3, 4, 2, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h12345678, 32'h0,        32'h0,        1};
    tbl[8]  = '{1, 4, 2, 5, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hB,        32'hA,        32'hCAFEF00D, 1};
    tbl[9]  = '{0, 0, 0, 0, 1, 1, 32'h33,       1, 1, 6, 32'h11,       32'h0,        32'h0,        32'h0,        1};
    tbl[10] = '{0, 6, 6, 6, 1, 6, 32'h22,       0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    tbl[11] = '{1, 6, 1, 6, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h22,       32'h33,       32'h22,       1};
    tbl[12] = '{0, 0, 0, 0, 1, 7, 32'h44,       1, 1, 7, 32'h55,       32'h0,        32'h0,        32'h0,        1};
    tbl[13] = '{1, 7, 7, 7, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h44,       32'h44,       32'h44,       1};
    tbl[14] = '{0, 3, 3, 3, 1, 0, 32'h66,       1, 1, 3, 32'h77,       32'h12345678, 32'h12345678, 32'h12345678, 1};
    tbl[15] = '{0, 3, 0, 0, 1, 1, 32'h88,       0, 0, 0, 32'h0,        32'h12345678, 32'h0,        32'h0,        0};
    tbl[16] = '{1, 3, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h77,       32'h88,       32'h66,       0};
    tbl[17] = '{0, 3, 3, 3, 1, 5, 32'hDD,       1, 0, 2, 32'h99,       32'h12345678, 32'h12345678, 32'h12345678, 1};
    tbl[18] = '{1, 3, 0, 5, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h77,       32'h66,       32'hDD,       1};
    tbl[19] = '{0, 2, 3, 2, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h99,       32'h12345678, 32'h99,       1};
    tbl[20] = '{1, 0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'hEE,       32'h66,       32'h66,       32'h66,       1};
    tbl[21] = '{1, 0, 3, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hEE,       32'h77,       32'hEE,       1};

    // Reset held while writes are presented.
    rst_n = 1'b0;
    slice = 1'b0; ra_sel = '0; rb_sel = '0; ld_sel = '0;
    au_vld = 1'b1; au_sel = 3'd3; au_d = 32'hDEADBEEF;
    ls_vld = 1'b1; ls_slice = 1'b1; ls_sel = 3'd3; ls_d = 32'hBADC0DE0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst.rdy_in_reset", {31'd0, ls_rdy}, 32'd1);
    idle();
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 8; r++) begin
        slice = s[0]; ra_sel = r[2:0]; rb_sel = r[2:0]; ld_sel = r[2:0];
        #1;
        chk("rst.ra", ra, 32'h0);
        chk("rst.rb", rb, 32'h0);
        chk("rst.ld", ld, 32'h0);
      end
    chk("rst.rdy", {31'd0, ls_rdy}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d.ra", i), ra, tbl[i].e_ra);
      chk($sformatf("vec%0d.rb", i), rb, tbl[i].e_rb);
      chk($sformatf("vec%0d.ld", i), ld, tbl[i].e_ld);
      chk($sformatf("vec%0d.rdy", i), {31'd0, ls_rdy}, {31'd0, tbl[i].e_rdy});
      step();
    end

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) != 0) slice = ~slice;
      ra_sel = 3'($urandom_range(7)); rb_sel = 3'($urandom_range(7)); ld_sel = 3'($urandom_range(7));
      au_vld = ($urandom_range(9) < 6); au_sel = 3'($urandom_range(3)); au_d = $urandom;
      ls_vld = ($urandom_range(9) < 7); ls_slice = 1'($urandom_range(1));
      ls_sel = 3'($urandom_range(3)); ls_d = $urandom;
      #1;
      chk_model($sformatf("rnd%0d", n));
      step();
    end

    // Asynchronous reset while a load sits in the pending buffer.
    idle();
    slice = 1'b1; step();
    slice = 1'b0; step();
    slice = 1'b0; au_vld = 1'b1; au_sel = 3'd2; au_d = 32'h1;
    ls_vld = 1'b1; ls_slice = 1'b1; ls_sel = 3'd5; ls_d = 32'hABCD;
    #1;
    chk("mid.rdy_before", {31'd0, ls_rdy}, 32'd1);
    step();
    idle();
    slice = 1'b1; ra_sel = 3'd2; rb_sel = 3'd0; ld_sel = 3'd5;
    #1;
    chk("mid.rdy_pending", {31'd0, ls_rdy}, 32'd0);
    chk("mid.fwd", ld, 32'hABCD);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.rdy_async", {31'd0, ls_rdy}, 32'd1);
    chk("mid.ld_async", ld, 32'h0);
    m_reset();
    #1 rst_n = 1'b1;
    step();
    slice = 1'b1;
    #1;
    chk("mid.ld_after", ld, 32'h0);
    chk("mid.ra_after", ra, 32'h0);
    chk("mid.rdy_after", {31'd0, ls_rdy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
